// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - issue/collect sequencer driving a 16-bit ADD/SUB/AND/OR ALU
// Runs 1 pass for ADD/SUB/AND/OR/SLT/BEQ/BNE and 3 passes for XOR, then holds the response.
module alu_issue_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [1:0]  alu_ctrl,
  input  logic [15:0] alu_answer,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_taken
);

  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_BEQ = 3'b110;
  localparam logic [2:0] OP_BNE = 3'b111;

  localparam logic [1:0] CTRL_SUB = 2'b01;
  localparam logic [1:0] CTRL_AND = 2'b10;
  localparam logic [1:0] CTRL_OR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [2:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [15:0] t1;
  logic [15:0] t2;

  logic [1:0]  first_ctrl;
  logic        slt_ovf;
  logic [15:0] single_result;
  logic        single_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = S_P1;
      S_P1:   state_nxt = (op_q == OP_XOR) ? S_P2 : S_RESP;
      S_P2:   state_nxt = S_P3;
      S_P3:   state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
  end

  // Pass-1 control: plain ops map directly; XOR starts with OR, the rest are a SUB.
  always_comb begin
    if (!req_op[2]) begin
      first_ctrl = req_op[1:0];
    end else if (req_op == OP_XOR) begin
      first_ctrl = CTRL_OR;
    end else begin
      first_ctrl = CTRL_SUB;
    end
  end

  // Signed a<b from a-b: the sign bit lies exactly when the subtraction overflowed.
  always_comb begin
    slt_ovf      = (a_q[15] != b_q[15]) && (alu_answer[15] != a_q[15]);
    single_taken = 1'b0;
    if (op_q == OP_SLT) begin
      single_result = {15'b0, alu_answer[15] ^ slt_ovf};
    end else begin
      single_result = alu_answer;
    end
    if (op_q == OP_BEQ) begin
      single_taken = alu_zero;
    end else if (op_q == OP_BNE) begin
      single_taken = !alu_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 3'b000;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      t1         <= 16'h0000;
      t2         <= 16'h0000;
      alu_in1    <= 16'h0000;
      alu_in2    <= 16'h0000;
      alu_ctrl   <= 2'b00;
      rsp_result <= 16'h0000;
      rsp_zero   <= 1'b0;
      rsp_taken  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            a_q      <= req_a;
            b_q      <= req_b;
            alu_in1  <= req_a;
            alu_in2  <= req_b;
            alu_ctrl <= first_ctrl;
          end
        end
        S_P1: begin
          if (op_q == OP_XOR) begin
            t1       <= alu_answer;
            alu_in1  <= a_q;
            alu_in2  <= b_q;
            alu_ctrl <= CTRL_AND;
          end else begin
            rsp_result <= single_result;
            rsp_zero   <= (single_result == 16'h0000);
            rsp_taken  <= single_taken;
            alu_in1    <= 16'h0000;
            alu_in2    <= 16'h0000;
            alu_ctrl   <= 2'b00;
          end
        end
        S_P2: begin
          // a^b = (a|b) - (a&b); the AND result feeds the last pass directly.
          t2       <= alu_answer;
          alu_in1  <= t1;
          alu_in2  <= alu_answer;
          alu_ctrl <= CTRL_SUB;
        end
        S_P3: begin
          rsp_result <= alu_answer;
          rsp_zero   <= (alu_answer == 16'h0000);
          rsp_taken  <= 1'b0;
          alu_in1    <= 16'h0000;
          alu_in2    <= 16'h0000;
          alu_ctrl   <= 2'b00;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - randomized and directed bench for alu_issue_unit
// Transaction-level reference model, per-cycle compare, literal pins for the named cases.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [1:0]  alu_ctrl;
  logic [15:0] alu_answer;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_taken;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  alu_issue_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_ctrl   (alu_ctrl),
    .alu_answer (alu_answer),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_taken  (rsp_taken)
  );

  // The combinational ALU the unit drives.
  always_comb begin
    alu_answer = 16'h0000;
    case (alu_ctrl)
      2'b00: alu_answer = alu_in1 + alu_in2;
      2'b01: alu_answer = alu_in1 - alu_in2;
      2'b10: alu_answer = alu_in1 & alu_in2;
      2'b11: alu_answer = alu_in1 | alu_in2;
      default: alu_answer = 16'h0000;
    endcase
  end
  assign alu_zero = (alu_answer == 16'h0000);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd5: return a ^ b;
      default: return a - b;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 3'd6) return a == b;
    if (op == 3'd7) return a != b;
    return 1'b0;
  endfunction

  // {ctrl, in1, in2} the ALU must see during the given pass (0 = not executing).
  function automatic logic [33:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input int pass);
    if (pass == 0) return 34'd0;
    if (op == 3'd5) begin
      if (pass == 1) return {2'b11, a, b};
      if (pass == 2) return {2'b10, a, b};
      return {2'b01, a | b, a & b};
    end
    return {(op < 3'd4) ? op[1:0] : 2'b01, a, b};
  endfunction

  bit          m_idle = 1;
  bit          m_resp = 0;
  int          m_pass = 0;
  logic [2:0]  m_op;
  logic [15:0] m_a;
  logic [15:0] m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle = 1;
      m_resp = 0;
      m_pass = 0;
    end else if (m_idle) begin
      if (req_valid) begin
        m_idle = 0;
        m_pass = 1;
        m_op   = req_op;
        m_a    = req_a;
        m_b    = req_b;
      end
    end else if (m_pass > 0) begin
      if (m_pass == ((m_op == 3'd5) ? 3 : 1)) begin
        m_pass = 0;
        m_resp = 1;
      end else begin
        m_pass++;
      end
    end else if (m_resp && rsp_ready) begin
      m_resp = 0;
      m_idle = 1;
    end
  end

  always @(negedge clk) begin
    logic [33:0] ea;
    logic [15:0] er;
    if (chk_en) begin
      ea = ref_alu(m_op, m_a, m_b, m_pass);
      check("req_ready", 32'(req_ready), 32'(m_idle));
      check("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      check("alu_ctrl", 32'(alu_ctrl), 32'(ea[33:32]));
      check("alu_in1", 32'(alu_in1), 32'(ea[31:16]));
      check("alu_in2", 32'(alu_in2), 32'(ea[15:0]));
      if (m_resp) begin
        er = ref_result(m_op, m_a, m_b);
        check("rsp_result", 32'(rsp_result), 32'(er));
        check("rsp_zero", 32'(rsp_zero), 32'(er == 16'h0000));
        check("rsp_taken", 32'(rsp_taken), 32'(ref_taken(m_op, m_a, m_b)));
      end
    end
  end

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic drain();
    bit got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    check("drain_arrival", 32'(got), 32'd1);
    release_rsp();
  endtask

  // Entered and left at posedge+1 with the unit idle.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input bit pend,
                        input logic [15:0] er, input logic ez, input logic et);
    logic [1:0] ctrls [3];
    int lat = 0;
    bit got = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        lat = k;
      end else if (k <= 3) begin
        ctrls[k-1] = alu_ctrl;
      end
    end
    check("rsp_arrival", 32'(got), 32'd1);
    check("latency_edges", 32'(lat), (op == 3'd5) ? 32'd4 : 32'd2);
    check("lit_result", 32'(rsp_result), 32'(er));
    check("lit_zero", 32'(rsp_zero), 32'(ez));
    check("lit_taken", 32'(rsp_taken), 32'(et));
    if (op == 3'd5) begin
      check("xor_ctrl_p1", 32'(ctrls[0]), 32'd3);
      check("xor_ctrl_p2", 32'(ctrls[1]), 32'd2);
      check("xor_ctrl_p3", 32'(ctrls[2]), 32'd1);
    end
    for (int h = 0; h < hold; h++) begin
      if (pend) begin
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 16'd5;
        req_b     = 16'd7;
      end
      @(negedge clk);
      check("bp_result_held", 32'(rsp_result), 32'(er));
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    release_rsp();
    if (pend) begin
      @(negedge clk);
      check("pend_ready_after_handoff", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("pend_accepted_in1", 32'(alu_in1), 32'd5);
      check("pend_accepted_in2", 32'(alu_in2), 32'd7);
      check("pend_ready_low", 32'(req_ready), 32'd0);
      drain();
    end
  endtask

  function automatic logic [15:0] pick_operand(input logic [15:0] other);
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      4: return other;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 16'h0000;
    req_b     = 16'h0000;
    rsp_ready = 1'b0;
    chk_en    = 1;
    @(negedge clk);
    check("reset_rsp_result", 32'(rsp_result), 32'd0);
    check("reset_rsp_zero", 32'(rsp_zero), 32'd0);
    check("reset_rsp_taken", 32'(rsp_taken), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(3'd0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1'b1, 1'b0);
    run_op(3'd1, 16'h0003, 16'h0005, 0, 0, 16'hFFFE, 1'b0, 1'b0);
    run_op(3'd4, 16'h8000, 16'h0001, 0, 0, 16'h0001, 1'b0, 1'b0);
    run_op(3'd4, 16'h7FFF, 16'hFFFF, 0, 0, 16'h0000, 1'b1, 1'b0);
    run_op(3'd4, 16'h1234, 16'h1234, 0, 0, 16'h0000, 1'b1, 1'b0);
    run_op(3'd5, 16'hF0F0, 16'hFF00, 0, 0, 16'h0FF0, 1'b0, 1'b0);
    run_op(3'd6, 16'h00AA, 16'h00AA, 0, 0, 16'h0000, 1'b1, 1'b1);
    run_op(3'd7, 16'h00AA, 16'h00AA, 0, 0, 16'h0000, 1'b1, 1'b0);
    run_op(3'd7, 16'h0001, 16'h0002, 0, 0, 16'hFFFF, 1'b0, 1'b1);
    run_op(3'd2, 16'hF0F0, 16'h3C3C, 5, 1, 16'h3030, 1'b0, 1'b0);

    // Reset while the XOR is in its second pass.
    req_valid = 1'b1;
    req_op    = 3'd5;
    req_a     = 16'h1234;
    req_b     = 16'h00FF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_xor_ctrl_p2", 32'(alu_ctrl), 32'd2);
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_alu_in1", 32'(alu_in1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_op    = 3'($urandom);
      req_a     = pick_operand(16'($urandom));
      req_b     = pick_operand(req_a);
      rsp_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
